// File: rtl/if_stage_if.sv
// IF-stage bus: instruction-memory port, ID-stage control inputs, IF/ID outputs and perf counters.
// master = the fetch stage, slave = the surrounding pipeline / memory.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        wpcir;
  logic        branch;
  logic        jump;
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  modport master (
    input  imem_data, wpcir, branch, jump,
    output imem_addr, if_instr, id_instr, id_pc4, id_valid,
           perf_cycles, perf_stalls, perf_flushes
  );

  modport slave (
    output imem_data, wpcir, branch, jump,
    input  imem_addr, if_instr, id_instr, id_pc4, id_valid,
           perf_cycles, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register with load-use stall and ID-resolved beq/j redirect (no delay slot).
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;
  logic [31:0] next_pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [31:0] instr);
    logic signed [31:0] offset;
    offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    return pc4 + $unsigned(offset);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

  assign pc4_p0 = pc_p0 + 32'd4;

  // Targets come from the instruction currently held in IF/ID
  always_comb begin
    next_pc_p0 = pc4_p0;
    if (bus.branch)
      next_pc_p0 = bus.jump ? jump_target(pc4_p1, instr_p1) : branch_target(pc4_p1, instr_p1);
  end

  // IF -> ID boundary; a stall freezes everything, so a redirect raised during it is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= 32'h0000_0000;
      vld_p1   <= 1'b0;
    end else if (!bus.wpcir) begin
      pc_p0  <= next_pc_p0;
      pc4_p1 <= pc4_p0;
      if (bus.branch) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else begin
        instr_p1 <= bus.imem_data;
        vld_p1   <= 1'b1;
      end
    end
  end

  assign bus.imem_addr = pc_p0;
  assign bus.if_instr  = bus.imem_data;
  assign bus.id_instr  = instr_p1;
  assign bus.id_pc4    = pc4_p1;
  assign bus.id_valid  = vld_p1;

`ifdef IF_PERF_CNT_EN
  logic [31:0] cycles_cnt;
  logic [31:0] stalls_cnt;
  logic [31:0] flushes_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_cnt  <= 32'd0;
      stalls_cnt  <= 32'd0;
      flushes_cnt <= 32'd0;
    end else begin
      cycles_cnt <= cycles_cnt + 32'd1;
      if (bus.wpcir)
        stalls_cnt <= stalls_cnt + 32'd1;
      if (bus.branch && !bus.wpcir)
        flushes_cnt <= flushes_cnt + 32'd1;
    end
  end

  assign bus.perf_cycles  = cycles_cnt;
  assign bus.perf_stalls  = stalls_cnt;
  assign bus.perf_flushes = flushes_cnt;
`else
  assign bus.perf_cycles  = 32'd0;
  assign bus.perf_stalls  = 32'd0;
  assign bus.perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed vectors push expected IF/ID state, a monitor pops and compares.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  if_stage_if bus();

  if_stage dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Instruction memory: a few planted control-flow words, otherwise 0x1111_0000 + address
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_001C: return 32'h1000_0003;   // beq, +3 words
      32'h0000_0030: return 32'h0800_0040;   // j 0x40
      32'h0000_0108: return 32'h1000_FFBB;   // beq, -0x45 words
      32'hFFFF_FFF8: return 32'h0800_0040;   // j 0x40 in the 0xF region
      32'hF000_0100: return 32'h0BFF_FFFF;   // j to top word of the 0xF region
      default:       return a + 32'h1111_0000;
    endcase
  endfunction

  always_comb bus.imem_data = mem(bus.imem_addr);

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fl;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  logic [31:0] m_cyc = 0, m_stl = 0, m_fl = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s#%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Called at a negedge: drive inputs for the coming edge, queue the state expected after it
  task automatic vec(input logic w, input logic b, input logic j,
                     input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] pc4, input logic v);
    exp_t e;
    bus.wpcir  = w;
    bus.branch = b;
    bus.jump   = j;
    nvec++;
    m_cyc++;
    if (w) m_stl++;
    if (b && !w) m_fl++;
    e.id = nvec; e.pc = pc; e.instr = instr; e.pc4 = pc4; e.v = v;
    e.cyc = PERF ? m_cyc : 32'd0;
    e.stl = PERF ? m_stl : 32'd0;
    e.fl  = PERF ? m_fl  : 32'd0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc",       e.id, bus.imem_addr, e.pc);
        chk("id_instr", e.id, bus.id_instr,  e.instr);
        chk("id_pc4",   e.id, bus.id_pc4,    e.pc4);
        chk("id_valid", e.id, {31'd0, bus.id_valid}, {31'd0, e.v});
        chk("cycles",   e.id, bus.perf_cycles,  e.cyc);
        chk("stalls",   e.id, bus.perf_stalls,  e.stl);
        chk("flushes",  e.id, bus.perf_flushes, e.fl);
      end
    end
  end

  initial begin : stimulus
    bus.wpcir  = 1'b0;
    bus.branch = 1'b0;
    bus.jump   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc",      0, bus.imem_addr, 32'h0);
    chk("rst_instr",   0, bus.id_instr,  32'h0);
    chk("rst_pc4",     0, bus.id_pc4,    32'h0);
    chk("rst_valid",   0, {31'd0, bus.id_valid}, 32'd0);
    chk("rst_cycles",  0, bus.perf_cycles, 32'd0);
    chk("rst_if_instr",0, bus.if_instr, 32'h1111_0000);

    rst = 1'b1;
    // sequential fetch from reset
    vec(0,0,0, 32'h04, 32'h1111_0000, 32'h04, 1);
    vec(0,0,0, 32'h08, 32'h1111_0004, 32'h08, 1);
    vec(0,0,0, 32'h0C, 32'h1111_0008, 32'h0C, 1);
    vec(0,0,0, 32'h10, 32'h1111_000C, 32'h10, 1);
    // two-cycle stall at PC 0x10
    vec(1,0,0, 32'h10, 32'h1111_000C, 32'h10, 1);
    vec(1,0,0, 32'h10, 32'h1111_000C, 32'h10, 1);
    vec(0,0,0, 32'h14, 32'h1111_0010, 32'h14, 1);
    vec(0,0,0, 32'h18, 32'h1111_0014, 32'h18, 1);
    vec(0,0,0, 32'h1C, 32'h1111_0018, 32'h1C, 1);
    vec(0,0,0, 32'h20, 32'h1000_0003, 32'h20, 1);
    // branch raised during stall is ignored
    vec(1,1,0, 32'h20, 32'h1000_0003, 32'h20, 1);
    // taken beq to 0x2C
    vec(0,1,0, 32'h2C, 32'h0000_0000, 32'h24, 0);
    vec(0,0,0, 32'h30, 32'h1111_002C, 32'h30, 1);
    vec(0,0,0, 32'h34, 32'h0800_0040, 32'h34, 1);
    // taken j to 0x100
    vec(0,1,1, 32'h100, 32'h0000_0000, 32'h38, 0);
    vec(0,0,0, 32'h104, 32'h1111_0100, 32'h104, 1);
    // jump without branch is a plain fetch
    vec(0,0,1, 32'h108, 32'h1111_0104, 32'h108, 1);
    vec(0,0,0, 32'h10C, 32'h1000_FFBB, 32'h10C, 1);
    // backward beq wraps below zero
    vec(0,1,0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h110, 0);
    vec(0,0,0, 32'hFFFF_FFFC, 32'h0800_0040, 32'hFFFF_FFFC, 1);
    // j keeps id_pc4[31:28]; the IF/ID PC+4 wraps to 0
    vec(0,1,1, 32'hF000_0100, 32'h0000_0000, 32'h0000_0000, 0);
    vec(0,0,0, 32'hF000_0104, 32'h0BFF_FFFF, 32'hF000_0104, 1);
    vec(0,1,1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hF000_0108, 0);
    // PC wraps 0xFFFF_FFFC -> 0
    vec(0,0,0, 32'h0000_0000, 32'h1110_FFFC, 32'h0000_0000, 1);
    vec(0,0,0, 32'h0000_0004, 32'h1111_0000, 32'h0000_0004, 1);

    // async reset mid-cycle with a redirect pending
    bus.branch = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_pc",       99, bus.imem_addr, 32'h0);
    chk("arst_instr",    99, bus.id_instr,  32'h0);
    chk("arst_pc4",      99, bus.id_pc4,    32'h0);
    chk("arst_valid",    99, {31'd0, bus.id_valid}, 32'd0);
    chk("arst_stalls",   99, bus.perf_stalls, 32'd0);
    chk("arst_if_instr", 99, bus.if_instr,  32'h1111_0000);
    @(negedge clk);
    rst = 1'b1;
    m_cyc = 0; m_stl = 0; m_fl = 0;
    vec(0,0,0, 32'h04, 32'h1111_0000, 32'h04, 1);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined CPU; it sits directly upstream of the decode-stage control unit. Holds the PC, drives the instruction-memory address, and latches the fetched word into IF/ID. Obeys the control unit's load-use stall (`wpcir`) and resolves taken `beq`/`j` in ID by redirecting the PC and flushing the wrong-path word. No branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned)
- `NOP_INSTR`, 32'h0000_0000, bubble word inserted into IF/ID on flush and reset

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset: one clock; reset is asynchronous and active-low
- `imem_data`  in  32  instruction word at `imem_addr`, combinational read
- `wpcir`  in  1  stall: 1 = hold PC and IF/ID
- `branch`  in  1  taken redirect from ID (taken `beq` or `j`)
- `jump`  in  1  redirect is `j` (valid only with `branch`=1)
- `imem_addr`  out  32  current PC
- `if_instr`  out  32  word being fetched (= `imem_data`), fed to control unit
- `id_instr`  out  32  IF/ID instruction register
- `id_pc4`  out  32  IF/ID PC+4 register
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble)
- `perf_cycles`, `perf_stalls`, `perf_flushes`  out  32 each  performance counters (see Configuration)

## Operation
- `pc4` = `pc` + 4, modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Branch target `bt` = `id_pc4` + {{14{`id_instr`[15]}}, `id_instr`[15:0], 2'b00}, modulo 2^32.
- Jump target `jt` = {`id_pc4`[31:28], `id_instr`[25:0], 2'b00}.
- Per edge, priority order:
  1. `wpcir`=1: `pc`, `id_instr`, `id_pc4`, `id_valid` hold; `branch`/`jump` ignored, because the ID operands are not yet resolved.
  2. `branch`=1: `pc` <= `jump` ? `jt` : `bt`; `id_instr` <= `NOP_INSTR`; `id_pc4` <= `pc4`; `id_valid` <= 0. The fetched wrong-path word is discarded.
  3. Otherwise: `pc` <= `pc4`; `id_instr` <= `imem_data`; `id_pc4` <= `pc4`; `id_valid` <= 1.
- `jump`=1 with `branch`=0: no redirect; treated as case 3.
- A redirect is taken at most once per ID instruction. The flush leaves a NOP in ID on the next cycle, so a back-to-back redirect cannot occur.
- Target low bits are always 2'b00. Misaligned `RESET_PC` is a configuration error and is not checked.

## Timing
- Reset (`rst`=0, asynchronous): `pc`=`RESET_PC`, `id_instr`=`NOP_INSTR`, `id_pc4`=0, `id_valid`=0, all counters 0. `imem_addr` follows `pc` immediately.
- First edge after `rst` deasserts: the word at `RESET_PC` enters IF/ID.
- Fetch-to-ID latency: 1 cycle. Redirect penalty: 1 bubble. Stall: 1 extra cycle per asserted cycle.
- `if_instr` is combinational from `imem_data`. All other outputs are registered.
- Reset asserted mid-stall or mid-redirect: state returns to reset values at once, and the pending redirect is lost.

## Configuration
- `IF_PERF_CNT_EN` defined: three 32-bit wrapping counters, each updated per edge when not in reset:
  - `perf_cycles`: +1 every edge.
  - `perf_stalls`: +1 when `wpcir`=1.
  - `perf_flushes`: +1 when `branch`=1 and `wpcir`=0.
- `IF_PERF_CNT_EN` undefined: counter logic is not built; the three ports are tied to 0.

## Test plan
- Reset and fetch: `RESET_PC`=0, release `rst`; memory returns 32'h1111_0000+addr. Require `imem_addr` 0,4,8,…; `id_instr` 32'h1111_0000, 32'h1111_0004, … one cycle later; `id_valid`=1 from the first edge.
- Stall: assert `wpcir` for 2 cycles while PC=0x10. Require `imem_addr` to stay 0x10 for 2 extra cycles and `id_instr`/`id_pc4` to be unchanged; with the macro defined, `perf_stalls`=2.
- Taken beq: `id_instr`=32'h1000_0003, `id_pc4`=0x20, `branch`=1. Require next `pc`=0x2C, `id_instr`=0, `id_valid`=0, then the word at 0x2C in ID.
- Jump: `id_instr`=32'h0800_0040, `id_pc4`=0x3000_0008, `branch`=`jump`=1. Require next `pc`=0x3000_0100 and one bubble.
- Stall with branch in the same cycle: `wpcir`=1, `branch`=1. Require no redirect and no counter flush increment; PC unchanged.
- Wrap and async reset: PC=0xFFFF_FFFC, no stall → next PC=0. Drop `rst` mid-cycle → `imem_addr`=`RESET_PC` before the next edge.
